// File: rtl/sam_stream_pkg.sv
// Shared sparse-stream word definitions: width, control flag, done token and token helpers.
package sam_stream_pkg;

  localparam int unsigned STREAM_W = 17;
  localparam int unsigned CTRL_BIT = STREAM_W - 1;
  localparam int unsigned STOP_W   = 16;

  typedef logic [STREAM_W-1:0] stream_word_t;

  localparam stream_word_t DONE_TOKEN = {1'b1, 16'h0100};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } fwd_state_e;

  // True for the end-of-stream token.
  function automatic logic is_done(input stream_word_t w);
    return w == DONE_TOKEN;
  endfunction

  // True for any control word other than the done token.
  function automatic logic is_stop(input stream_word_t w);
    return w[CTRL_BIT] && (w != DONE_TOKEN);
  endfunction

endpackage

// File: rtl/repsig_stream_arbiter_if.sv
// Valid/ready stream link; master drives data and valid, slave drives ready.
interface repsig_stream_arbiter_if #(
  parameter int unsigned DATA_WIDTH = sam_stream_pkg::STREAM_W
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/rsg_order_fifo.sv
// In-order queue of 1-bit grant IDs; remembers which requester owns each RSG reply stream.
module rsg_order_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_en,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage, pointers and occupancy; push and pop together leave the count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clk_en) begin
      if (do_push) begin
        mem_q[wr_q] <= push_id;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + AW'(1);
      end
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + CW'(1);
      end else if (do_pop && !do_push) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  assign head  = mem_q[rd_q];
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/repsig_stream_arbiter.sv
// Shares one RSG between two requesters: whole-stream forward grant, in-order reply steering.
module repsig_stream_arbiter
  import sam_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = STREAM_W,
  parameter int unsigned ORDER_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_en,
  input  logic                 tile_en,
  input  logic [STOP_W-1:0]    stop_lvl0,
  input  logic [STOP_W-1:0]    stop_lvl1,
  repsig_stream_arbiter_if.slave  in0,
  repsig_stream_arbiter_if.slave  in1,
  repsig_stream_arbiter_if.master base_out,
  output logic [STOP_W-1:0]    stop_lvl_out,
  repsig_stream_arbiter_if.slave  rs_in,
  repsig_stream_arbiter_if.master rs0,
  repsig_stream_arbiter_if.master rs1,
  output logic                 grant_id,
  output logic                 grant_active
);

  fwd_state_e          state_q, state_d;
  logic                rr_q, rr_d;
  logic [STOP_W-1:0]   stop_q, stop_d;
  logic                en_c;
  logic                push, push_id, pop;
  logic                q_head, q_full, q_empty;
  logic [DATA_WIDTH-1:0] in0_word_c, in1_word_c, rs_word_c;

  assign en_c       = clk_en & tile_en;
  assign in0_word_c = in0.data;
  assign in1_word_c = in1.data;
  assign rs_word_c  = rs_in.data;

  // Forward owner, round-robin pointer and stop level registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rr_q    <= 1'b0;
      stop_q  <= '0;
    end else if (clk_en) begin
      state_q <= state_d;
      rr_q    <= rr_d;
      stop_q  <= stop_d;
    end
  end

  // Grant decision in IDLE; zero-latency pass-through of the owner while locked.
  always_comb begin
    state_d        = state_q;
    rr_d           = rr_q;
    stop_d         = stop_q;
    push           = 1'b0;
    push_id        = 1'b0;
    in0.ready      = 1'b0;
    in1.ready      = 1'b0;
    base_out.valid = 1'b0;
    base_out.data  = in0_word_c;
    unique case (state_q)
      ST_IDLE: begin
        if (en_c && !q_full && (in0.valid || in1.valid)) begin
          push_id = (in0.valid && in1.valid) ? rr_q : in1.valid;
          push    = 1'b1;
          state_d = push_id ? ST_LOCK1 : ST_LOCK0;
          stop_d  = push_id ? stop_lvl1 : stop_lvl0;
        end
      end
      ST_LOCK0: begin
        base_out.data  = in0_word_c;
        base_out.valid = in0.valid & tile_en;
        in0.ready      = base_out.ready & tile_en;
        if (en_c && in0.valid && base_out.ready && is_done(in0_word_c)) begin
          state_d = ST_IDLE;
          rr_d    = 1'b1;
        end
      end
      ST_LOCK1: begin
        base_out.data  = in1_word_c;
        base_out.valid = in1.valid & tile_en;
        in1.ready      = base_out.ready & tile_en;
        if (en_c && in1.valid && base_out.ready && is_done(in1_word_c)) begin
          state_d = ST_IDLE;
          rr_d    = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Return path follows the oldest outstanding grant; its done token retires it.
  always_comb begin
    rs0.data    = rs_word_c;
    rs1.data    = rs_word_c;
    rs0.valid   = ~q_empty & tile_en & ~q_head & rs_in.valid;
    rs1.valid   = ~q_empty & tile_en &  q_head & rs_in.valid;
    rs_in.ready = ~q_empty & tile_en & (q_head ? rs1.ready : rs0.ready);
    pop         = clk_en & rs_in.valid & rs_in.ready & is_done(rs_word_c);
  end

  rsg_order_fifo #(
    .DEPTH (ORDER_DEPTH)
  ) u_order (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk_en  (clk_en),
    .push    (push),
    .push_id (push_id),
    .pop     (pop),
    .head    (q_head),
    .full    (q_full),
    .empty   (q_empty)
  );

  assign stop_lvl_out = stop_q;
  assign grant_active = (state_q != ST_IDLE);
  assign grant_id     = (state_q == ST_LOCK1);

endmodule

// File: tb/tb_repsig_stream_arbiter.sv
// Randomized bench for repsig_stream_arbiter against a queue-based transaction model.
module tb_repsig_stream_arbiter;
  import sam_stream_pkg::*;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst_n, clk_en, tile_en;
  logic [15:0] stop_lvl0, stop_lvl1, stop_lvl_out;
  logic        grant_id, grant_active;

  repsig_stream_arbiter_if in0_if ();
  repsig_stream_arbiter_if in1_if ();
  repsig_stream_arbiter_if base_if ();
  repsig_stream_arbiter_if rsi_if ();
  repsig_stream_arbiter_if rs0_if ();
  repsig_stream_arbiter_if rs1_if ();

  repsig_stream_arbiter #(.DATA_WIDTH(17), .ORDER_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_en       (clk_en),
    .tile_en      (tile_en),
    .stop_lvl0    (stop_lvl0),
    .stop_lvl1    (stop_lvl1),
    .in0          (in0_if),
    .in1          (in1_if),
    .base_out     (base_if),
    .stop_lvl_out (stop_lvl_out),
    .rs_in        (rsi_if),
    .rs0          (rs0_if),
    .rs1          (rs1_if),
    .grant_id     (grant_id),
    .grant_active (grant_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // stimulus sources and the bench-side RSG reply queue
  logic [16:0] src0[$], src1[$], rsq[$];
  // transaction model: owner (-1 = none), round-robin, outstanding grant order, stop level
  int          m_owner;
  bit          m_rr;
  bit          m_q[$];
  logic [15:0] m_stop;
  int          fwd_done[2];
  // observations of the DUT
  int          obs_rs_done[2];
  int          obs_grants, obs_base_words;
  bit          obs_ids[$];
  bit          prev_ga, seen_rs1_valid;
  // knobs
  int p_v0, p_v1, p_br, p_rsv, p_r0, p_r1, p_ce, p_te, p_refill;
  bit hold_rs, rand_stop;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit coin(input int p);
    return int'($urandom_range(0, 99)) < p;
  endfunction

  task automatic gen_stream(input int which);
    int n;
    logic [16:0] w;
    n = int'($urandom_range(0, 3));
    for (int i = 0; i <= n; i++) begin
      if (i == n) w = DONE_TOKEN;
      else if (coin(20)) w = {1'b1, 16'($urandom_range(0, 255))};
      else w = {1'b0, 16'($urandom)};
      if (which == 0) src0.push_back(w);
      else src1.push_back(w);
    end
  endtask

  task automatic add_reply();
    rsq.push_back({1'b0, 16'($urandom)});
    rsq.push_back({1'b0, 16'($urandom)});
    rsq.push_back(17'h10000);
    rsq.push_back(DONE_TOKEN);
  endtask

  // Advance the model by one clock edge using the inputs the bench held across it.
  task automatic model_edge();
    int gid;
    bit do_push;
    logic [16:0] w;
    do_push = 1'b0;
    gid = 0;
    if (!rst_n) begin
      m_owner = -1; m_rr = 1'b0; m_stop = '0;
      m_q.delete(); rsq.delete();
      return;
    end
    if (!(clk_en && tile_en)) return;
    if (m_owner < 0) begin
      if (m_q.size() < DEPTH && (in0_if.valid || in1_if.valid)) begin
        gid = (in0_if.valid && in1_if.valid) ? int'(m_rr) : (in1_if.valid ? 1 : 0);
        do_push = 1'b1;
        m_owner = gid;
        m_stop = (gid == 1) ? stop_lvl1 : stop_lvl0;
      end
    end else if (m_owner == 0) begin
      if (in0_if.valid && base_if.ready) begin
        w = src0.pop_front();
        if (w == DONE_TOKEN) begin m_owner = -1; m_rr = 1'b1; fwd_done[0]++; add_reply(); end
      end
    end else begin
      if (in1_if.valid && base_if.ready) begin
        w = src1.pop_front();
        if (w == DONE_TOKEN) begin m_owner = -1; m_rr = 1'b0; fwd_done[1]++; add_reply(); end
      end
    end
    if (m_q.size() != 0 && rsi_if.valid && (m_q[0] ? rs1_if.ready : rs0_if.ready)) begin
      w = rsq.pop_front();
      if (w == DONE_TOKEN) void'(m_q.pop_front());
    end
    if (do_push) m_q.push_back(gid[0]);
  endtask

  task automatic drive();
    if (p_refill > 0 && src0.size() == 0 && coin(p_refill)) gen_stream(0);
    if (p_refill > 0 && src1.size() == 0 && coin(p_refill)) gen_stream(1);
    in0_if.valid  = (src0.size() != 0) && coin(p_v0);
    in0_if.data   = (src0.size() != 0) ? src0[0] : 17'($urandom);
    in1_if.valid  = (src1.size() != 0) && coin(p_v1);
    in1_if.data   = (src1.size() != 0) ? src1[0] : 17'($urandom);
    rsi_if.valid  = !hold_rs && (rsq.size() != 0) && coin(p_rsv);
    rsi_if.data   = (rsq.size() != 0) ? rsq[0] : 17'($urandom);
    base_if.ready = coin(p_br);
    rs0_if.ready  = coin(p_r0);
    rs1_if.ready  = coin(p_r1);
    clk_en        = coin(p_ce);
    tile_en       = coin(p_te);
    if (rand_stop) begin
      stop_lvl0 = 16'($urandom);
      stop_lvl1 = 16'($urandom);
    end
  endtask

  // Compare every DUT output with the model's view of the current cycle.
  task automatic compare();
    logic ebv, er0, er1, erv0, erv1, ersr;
    logic [16:0] ebd;
    ebv = 0; er0 = 0; er1 = 0; erv0 = 0; erv1 = 0; ersr = 0; ebd = '0;
    if (m_owner == 0) begin
      ebv = in0_if.valid & tile_en; er0 = base_if.ready & tile_en; ebd = in0_if.data;
    end else if (m_owner == 1) begin
      ebv = in1_if.valid & tile_en; er1 = base_if.ready & tile_en; ebd = in1_if.data;
    end
    if (m_q.size() != 0) begin
      if (m_q[0]) begin erv1 = rsi_if.valid & tile_en; ersr = rs1_if.ready & tile_en; end
      else begin erv0 = rsi_if.valid & tile_en; ersr = rs0_if.ready & tile_en; end
    end
    expect_eq("base_valid", 32'(base_if.valid), 32'(ebv));
    if (ebv) expect_eq("base_data", 32'(base_if.data), 32'(ebd));
    expect_eq("in0_ready", 32'(in0_if.ready), 32'(er0));
    expect_eq("in1_ready", 32'(in1_if.ready), 32'(er1));
    expect_eq("rs0_valid", 32'(rs0_if.valid), 32'(erv0));
    expect_eq("rs1_valid", 32'(rs1_if.valid), 32'(erv1));
    expect_eq("rs_in_ready", 32'(rsi_if.ready), 32'(ersr));
    if (erv0) expect_eq("rs0_data", 32'(rs0_if.data), 32'(rsi_if.data));
    if (erv1) expect_eq("rs1_data", 32'(rs1_if.data), 32'(rsi_if.data));
    expect_eq("grant_active", 32'(grant_active), 32'(m_owner >= 0));
    expect_eq("grant_id", 32'(grant_id), 32'(m_owner == 1));
    expect_eq("stop_lvl_out", 32'(stop_lvl_out), 32'(m_stop));
    // handshakes the DUT presents now complete at the next edge
    if (rst_n && clk_en) begin
      if (rs0_if.valid && rs0_if.ready && rs0_if.data == DONE_TOKEN) obs_rs_done[0]++;
      if (rs1_if.valid && rs1_if.ready && rs1_if.data == DONE_TOKEN) obs_rs_done[1]++;
      if (base_if.valid && base_if.ready) obs_base_words++;
    end
    if (rs1_if.valid) seen_rs1_valid = 1'b1;
    if (grant_active && !prev_ga) begin obs_grants++; obs_ids.push_back(grant_id); end
    prev_ga = grant_active;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    drive();
    #1;
    compare();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic all_on();
    p_v0 = 100; p_v1 = 100; p_br = 100; p_rsv = 100; p_r0 = 100; p_r1 = 100;
    p_ce = 100; p_te = 100;
  endtask

  // Two reset cycles with whatever sources are loaded, then clear observations.
  task automatic start_phase();
    rst_n = 1'b0;
    steps(2);
    obs_rs_done[0] = 0; obs_rs_done[1] = 0; fwd_done[0] = 0; fwd_done[1] = 0;
    obs_grants = 0; obs_base_words = 0; obs_ids.delete(); seen_rs1_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clk_en = 1'b1; tile_en = 1'b1;
    stop_lvl0 = 16'd3; stop_lvl1 = 16'd9;
    in0_if.valid = 0; in0_if.data = '0; in1_if.valid = 0; in1_if.data = '0;
    base_if.ready = 0; rsi_if.valid = 0; rsi_if.data = '0; rs0_if.ready = 0; rs1_if.ready = 0;
    m_owner = -1; m_rr = 0; m_stop = '0; prev_ga = 0;
    hold_rs = 0; rand_stop = 0; p_refill = 100;
    all_on();

    // reset with both requesters valid, then contention: strict alternation
    gen_stream(0); gen_stream(1);
    start_phase();
    expect_eq("rst_in0_ready", 32'(in0_if.ready), 0);
    expect_eq("rst_in1_ready", 32'(in1_if.ready), 0);
    expect_eq("rst_base_valid", 32'(base_if.valid), 0);
    expect_eq("rst_grant_active", 32'(grant_active), 0);
    rst_n = 1'b1;
    steps(80);
    expect_eq("contention_grants_ge6", 32'(obs_grants >= 6), 1);
    for (int i = 0; i < 6 && i < obs_ids.size(); i++)
      expect_eq($sformatf("contention_order%0d", i), 32'(obs_ids[i]), 32'(i % 2));

    // single requester with directed stream, freeze and tile-disable mid-stream
    p_refill = 0; src0.delete(); src1.delete();
    src0.push_back(17'd5); src0.push_back(17'd7); src0.push_back(17'h10000); src0.push_back(DONE_TOKEN);
    stop_lvl0 = 16'd3;
    start_phase();
    rst_n = 1'b1;
    step();
    expect_eq("single_grant_active", 32'(grant_active), 1);
    expect_eq("single_grant_id", 32'(grant_id), 0);
    expect_eq("single_stop_lvl", 32'(stop_lvl_out), 3);
    p_ce = 0; steps(3); p_ce = 100;
    expect_eq("freeze_grant_held", 32'(grant_active), 1);
    p_te = 0; steps(2);
    expect_eq("tile_off_in0_ready", 32'(in0_if.ready), 0);
    expect_eq("tile_off_base_valid", 32'(base_if.valid), 0);
    p_te = 100;
    steps(20);
    expect_eq("single_base_words", 32'(obs_base_words), 4);
    expect_eq("single_rs0_done", 32'(obs_rs_done[0]), 1);
    expect_eq("single_rs1_never_valid", 32'(seen_rs1_valid), 0);

    // order queue full: no returns until released
    src0.delete(); src1.delete();
    gen_stream(0); gen_stream(0); gen_stream(1); gen_stream(1);
    hold_rs = 1'b1;
    start_phase();
    rst_n = 1'b1;
    steps(30);
    expect_eq("qfull_grants", 32'(obs_grants), 2);
    expect_eq("qfull_idle", 32'(grant_active), 0);
    hold_rs = 1'b0;
    for (int i = 0; i < 20 && obs_grants < 3; i++) step();
    expect_eq("qfull_third_grant", 32'(obs_grants), 3);

    // randomized traffic with backpressure and enable toggling, then drain
    src0.delete(); src1.delete();
    p_refill = 30; rand_stop = 1'b1;
    start_phase();
    rst_n = 1'b1;
    p_v0 = 70; p_v1 = 70; p_br = 60; p_rsv = 60; p_r0 = 60; p_r1 = 40; p_ce = 85; p_te = 90;
    steps(3000);
    p_refill = 0;
    all_on();
    steps(400);
    expect_eq("drain_idle", 32'(grant_active), 0);
    expect_eq("drain_rs0_done", 32'(obs_rs_done[0]), 32'(fwd_done[0]));
    expect_eq("drain_rs1_done", 32'(obs_rs_done[1]), 32'(fwd_done[1]));
    expect_eq("random_streams_ran", 32'(obs_grants > 20), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
